// File: rtl/instr_fetch.sv
// Instruction fetch: one outstanding imem request at a time, with a 2-entry in-order {pc, instr} FIFO toward decode.
// A redirect flushes the FIFO and marks any in-flight response stale.
module instr_fetch #(
    parameter int unsigned     XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(32'h0000_0000)
) (
    input  logic            clk,
    input  logic            rstN,
    output logic            imemReq,
    output logic [XLEN-1:0] imemAddr,
    input  logic            imemReady,
    input  logic            imemRspValid,
    input  logic [XLEN-1:0] imemRspData,
    output logic            instrValid,
    output logic [XLEN-1:0] instr,
    output logic [XLEN-1:0] instrPc,
    input  logic            instrReady,
    input  logic            redirectValid,
    input  logic [XLEN-1:0] redirectPc
);
    localparam int unsigned DEPTH = 2;
    localparam int unsigned CNT_W = 2;

    typedef enum logic [1:0] {IDLE, REQ, WAIT, DROP} state_t;

    state_t           state;
    state_t           state_nxt;
    logic [XLEN-1:0]  fetch_pc;
    logic [XLEN-1:0]  issue_pc;
    logic [XLEN-1:0]  fifo_pc   [DEPTH];
    logic [XLEN-1:0]  fifo_data [DEPTH];
    logic             rd_ptr;
    logic             wr_ptr;
    logic [CNT_W-1:0] count;

    logic             in_flight;
    logic             accept;
    logic             push;
    logic             pop;

    // State register
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; a redirect overrides the normal transition.
    // A response landing in the redirect cycle retires the in-flight request, so no DROP is needed then.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:       state_nxt = REQ;
            REQ:        if (accept) state_nxt = WAIT;
            WAIT, DROP: if (imemRspValid) state_nxt = REQ;
            default:    state_nxt = IDLE;
        endcase
        if (redirectValid) begin
            if ((in_flight && !imemRspValid) || accept) begin
                state_nxt = DROP;
            end else begin
                state_nxt = REQ;
            end
        end
    end

    // Output and handshake decode
    always_comb begin
        in_flight  = (state == WAIT) || (state == DROP);
        imemReq    = (state == REQ) && ((count + CNT_W'(in_flight)) < CNT_W'(DEPTH));
        accept     = imemReq && imemReady;
        push       = (state == WAIT) && imemRspValid && !redirectValid;
        instrValid = (count != '0);
        pop        = instrValid && instrReady && !redirectValid;
        imemAddr   = fetch_pc;
        instr      = fifo_data[rd_ptr];
        instrPc    = fifo_pc[rd_ptr];
    end

    // Fetch PC and FIFO storage
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            fetch_pc <= RESET_PC;
            issue_pc <= RESET_PC;
            rd_ptr   <= 1'b0;
            wr_ptr   <= 1'b0;
            count    <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                fifo_pc[i]   <= '0;
                fifo_data[i] <= '0;
            end
        end else if (redirectValid) begin
            fetch_pc <= redirectPc & ~XLEN'(3);
            rd_ptr   <= 1'b0;
            wr_ptr   <= 1'b0;
            count    <= '0;
        end else begin
            if (accept) begin
                issue_pc <= fetch_pc;
                fetch_pc <= fetch_pc + XLEN'(4);
            end
            if (push) begin
                fifo_pc[wr_ptr]   <= issue_pc;
                fifo_data[wr_ptr] <= imemRspData;
                wr_ptr            <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: directed scenarios plus randomized traffic against a queue-based reference model.
module tb_instr_fetch;
    localparam logic [31:0] RST2 = 32'hFFFF_FFFC;

    logic        clk = 1'b0;
    logic        rstN;
    logic        imemReady, imemRspValid, instrReady, redirectValid;
    logic [31:0] imemRspData, redirectPc;
    logic        imemReq, instrValid, imemReq2, instrValid2;
    logic [31:0] imemAddr, instr, instrPc, imemAddr2, instr2, instrPc2;

    always #5 clk = ~clk;

    instr_fetch #(.XLEN(32), .RESET_PC(32'h0000_0000)) dut (
        .clk(clk), .rstN(rstN), .imemReq(imemReq), .imemAddr(imemAddr), .imemReady(imemReady),
        .imemRspValid(imemRspValid), .imemRspData(imemRspData), .instrValid(instrValid),
        .instr(instr), .instrPc(instrPc), .instrReady(instrReady),
        .redirectValid(redirectValid), .redirectPc(redirectPc)
    );

    instr_fetch #(.XLEN(32), .RESET_PC(RST2)) dut2 (
        .clk(clk), .rstN(rstN), .imemReq(imemReq2), .imemAddr(imemAddr2), .imemReady(imemReady),
        .imemRspValid(imemRspValid), .imemRspData(imemRspData), .instrValid(instrValid2),
        .instr(instr2), .instrPc(instrPc2), .instrReady(instrReady),
        .redirectValid(redirectValid), .redirectPc(redirectPc)
    );

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: queue of delivered pairs, fetch pointer and one in-flight request with a stale flag
    typedef struct packed {logic [31:0] pc; logic [31:0] data;} ent_t;
    ent_t        mq[$];
    logic [31:0] m_pc, m_pend_pc;
    bit          m_idle, m_pend, m_stale;
    bit          mem_out;
    int unsigned mem_wait;
    logic [31:0] acc_log[$], acc2_log[$], pop_log[$];
    bit          obs_req;
    logic [31:0] obs_addr;

    function automatic void model_reset();
        mq.delete();
        m_pc    = 32'h0;
        m_idle  = 1'b1;
        m_pend  = 1'b0;
        m_stale = 1'b0;
        mem_out = 1'b0;
    endfunction

    // One clock: check outputs at negedge, drive inputs for the next posedge, advance the model
    task automatic cycle(input bit rdy, input bit ir, input bit rv, input logic [31:0] rpc,
                         input int unsigned dly, input bit junk);
        bit          exp_req, rspv, acc;
        logic [31:0] rspd;
        @(negedge clk);
        exp_req = !m_idle && !m_pend && (mq.size() < 2);
        check("imemReq", 32'(imemReq), 32'(exp_req));
        check("imemAddr", imemAddr, m_pc);
        check("instrValid", 32'(instrValid), 32'(mq.size() != 0));
        check("imemReq2", 32'(imemReq2), 32'(exp_req));
        if (mq.size() != 0) begin
            check("instrPc", instrPc, mq[0].pc);
            check("instr", instr, mq[0].data);
        end
        obs_req  = imemReq;
        obs_addr = imemAddr;
        if (imemReq && rdy) begin
            acc_log.push_back(imemAddr);
            acc2_log.push_back(imemAddr2);
        end
        if (instrValid && ir && !rv) pop_log.push_back(instrPc);

        rspv = 1'b0;
        rspd = $urandom;
        if (mem_out) begin
            mem_wait--;
            if (mem_wait == 0) rspv = 1'b1;
        end else if (junk) begin
            rspv = 1'b1;
        end
        imemReady     = rdy;
        instrReady    = ir;
        redirectValid = rv;
        redirectPc    = rpc;
        imemRspValid  = rspv;
        imemRspData   = rspd;

        acc = exp_req && rdy;
        if (rv) begin
            mq.delete();
            m_pc = {rpc[31:2], 2'b00};
            if (m_pend) begin
                if (rspv) m_pend = 1'b0;
                else      m_stale = 1'b1;
            end else if (acc) begin
                m_pend  = 1'b1;
                m_stale = 1'b1;
            end
        end else begin
            if (ir && mq.size() != 0) void'(mq.pop_front());
            if (m_pend && rspv) begin
                if (!m_stale) mq.push_back('{pc: m_pend_pc, data: rspd});
                m_pend = 1'b0;
            end
            if (acc) begin
                m_pend_pc = m_pc;
                m_pc      = m_pc + 32'd4;
                m_pend    = 1'b1;
                m_stale   = 1'b0;
            end
        end
        if (mem_out && rspv) mem_out = 1'b0;
        if (acc) begin
            mem_out  = 1'b1;
            mem_wait = dly;
        end
        m_idle = 1'b0;
    endtask

    // Reset for cyc edges while a stray response is presented; release shortly after a posedge
    task automatic do_reset(input int unsigned cyc);
        @(negedge clk);
        rstN          = 1'b0;
        imemReady     = 1'b0;
        instrReady    = 1'b0;
        redirectValid = 1'b0;
        imemRspValid  = 1'b0;
        #1;
        check("rst_imemReq", 32'(imemReq), 32'h0);
        check("rst_imemAddr", imemAddr, 32'h0);
        check("rst_imemAddr2", imemAddr2, RST2);
        check("rst_instrValid", 32'(instrValid), 32'h0);
        check("rst_instr", instr, 32'h0);
        check("rst_instrPc", instrPc, 32'h0);
        repeat (cyc) begin
            imemRspValid = 1'b1;
            imemRspData  = $urandom;
            @(posedge clk);
            #1;
            check("rst_hold_valid", 32'(instrValid), 32'h0);
        end
        #1;
        imemRspValid = 1'b0;
        rstN         = 1'b1;
        model_reset();
    endtask

    initial begin
        logic [31:0] base;
        rstN = 1'b0; imemReady = 1'b0; imemRspValid = 1'b0; imemRspData = '0;
        instrReady = 1'b0; redirectValid = 1'b0; redirectPc = '0;
        model_reset();
        do_reset(2);

        // Back-to-back fetches with single-cycle memory
        acc_log.delete(); acc2_log.delete(); pop_log.delete();
        repeat (12) cycle(1'b1, 1'b1, 1'b0, 32'h0, 1, 1'b0);
        if (acc_log.size() >= 3 && pop_log.size() >= 3 && acc2_log.size() >= 2) begin
            for (int i = 0; i < 3; i++) begin
                check("seq_addr", acc_log[i], 32'(4 * i));
                check("seq_pc", pop_log[i], 32'(4 * i));
            end
            check("wrap_addr0", acc2_log[0], 32'hFFFF_FFFC);
            check("wrap_addr1", acc2_log[1], 32'h0000_0000);
        end else begin
            check("seq_count", 32'(acc_log.size()), 32'd5);
        end

        // Decode stalled: FIFO fills to two, requests stop, then drain in order
        repeat (8) cycle(1'b1, 1'b0, 1'b0, 32'h0, 1, 1'b0);
        repeat (4) begin
            cycle(1'b1, 1'b0, 1'b0, 32'h0, 1, 1'b0);
            check("stall_req", 32'(obs_req), 32'h0);
            check("stall_depth", 32'(mq.size()), 32'd2);
        end
        base = mq[0].pc;
        pop_log.delete(); acc_log.delete();
        repeat (10) cycle(1'b1, 1'b1, 1'b0, 32'h0, 1, 1'b0);
        if (pop_log.size() >= 3) begin
            for (int i = 0; i < 3; i++) check("drain_pc", pop_log[i], base + 32'(4 * i));
        end else begin
            check("drain_count", 32'(pop_log.size()), 32'd3);
        end
        check("resume_fetch", 32'(acc_log.size() != 0), 32'h1);

        // Memory not ready: request and address held
        repeat (3) cycle(1'b0, 1'b1, 1'b0, 32'h0, 1, 1'b0);
        base = m_pc;
        repeat (5) begin
            cycle(1'b0, 1'b1, 1'b0, 32'h0, 1, 1'b0);
            check("hold_req", 32'(obs_req), 32'h1);
            check("hold_addr", obs_addr, base);
        end

        // Redirect while waiting on a slow response
        cycle(1'b1, 1'b1, 1'b0, 32'h0, 3, 1'b0);
        cycle(1'b0, 1'b1, 1'b1, 32'h0000_1002, 3, 1'b0);
        acc_log.delete(); pop_log.delete();
        repeat (8) cycle(1'b1, 1'b1, 1'b0, 32'h0, 1, 1'b0);
        if (acc_log.size() != 0 && pop_log.size() != 0) begin
            check("redir_addr", acc_log[0], 32'h0000_1000);
            check("redir_pc", pop_log[0], 32'h0000_1000);
        end else begin
            check("redir_count", 32'(acc_log.size()), 32'd3);
        end

        // Reset while a request is outstanding, response arrives during reset
        for (int i = 0; i < 6 && !mem_out; i++) cycle(1'b1, 1'b1, 1'b0, 32'h0, 3, 1'b0);
        check("wait_before_reset", 32'(mem_out), 32'h1);
        do_reset(2);
        acc_log.delete();
        repeat (4) cycle(1'b1, 1'b1, 1'b0, 32'h0, 1, 1'b0);
        if (acc_log.size() != 0) check("post_rst_addr", acc_log[0], 32'h0);
        else                     check("post_rst_count", 32'(acc_log.size()), 32'd1);

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            logic [31:0] tgt;
            tgt = ($urandom % 4 == 0) ? (32'hFFFF_FFF0 | 32'($urandom % 16)) : 32'($urandom);
            if ($urandom % 600 == 0) do_reset(1);
            cycle($urandom % 4 != 0, $urandom % 3 != 0, $urandom % 12 == 0, tgt,
                  $urandom_range(1, 3), $urandom % 8 == 0);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
